// File: rtl/sumador_serie_param.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per cycle,
// LSB digit first, with start/done handshake and signed-overflow flag.
module sumador_serie_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CARRY_IN,
    input  logic             SUB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY_OUT,
    output logic             OVERFLOW
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nx;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;
    logic             last;
    logic             accept;

    // Operand registers shift right so the active digit is always at bit 0.
    always_comb begin
        {dcout, dsum} = {1'b0, a_r[DIGIT-1:0]}
                      + {1'b0, b_r[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_r};
        // Carry into the top bit of the digit, recovered from its sum bit.
        dcmsb = dsum[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
        res_nx = res_r;
        res_nx[int'(cnt)*DIGIT +: DIGIT] = dsum;
    end

    assign last   = (cnt == CW'(N - 1));
    assign accept = START && ((state == IDLE) || (state == FIN));
    assign BUSY   = (state == RUN);
    assign DONE   = (state == FIN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            res_r     <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            SUM       <= '0;
            CARRY_OUT <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else if (accept) begin
            state   <= RUN;
            a_r     <= A;
            b_r     <= B ^ {WIDTH{SUB}};
            carry_r <= SUB | CARRY_IN;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            res_r   <= res_nx;
            carry_r <= dcout;
            cnt     <= cnt + CW'(1);
            if (last) begin
                state     <= FIN;
                SUM       <= res_nx;
                CARRY_OUT <= dcout;
                OVERFLOW  <= dcmsb ^ dcout;
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_sumador_serie_param.sv
// Bench for sumador_serie_param: several parameterisations on one clock,
// checked against an arithmetic reference model.
module tb_sumador_serie_param;

    localparam int NC = 6;
    localparam int WS [NC] = '{8, 8, 8, 16, 2, 2};
    localparam int DS [NC] = '{2, 8, 1, 4, 1, 2};

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] start;
    logic [NC-1:0] cin;
    logic [NC-1:0] sub;
    logic [15:0]   a [NC];
    logic [15:0]   b [NC];
    wire  [NC-1:0] busy;
    wire  [NC-1:0] done;
    wire  [NC-1:0] co;
    wire  [NC-1:0] ov;
    wire  [15:0]   sumw [NC];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : u
        localparam int W = WS[g];
        localparam int D = DS[g];
        logic [W-1:0] s;
        sumador_serie_param #(.WIDTH(W), .DIGIT(D)) dut (
            .CLK      (clk),
            .RST      (rst),
            .START    (start[g]),
            .A        (a[g][W-1:0]),
            .B        (b[g][W-1:0]),
            .CARRY_IN (cin[g]),
            .SUB      (sub[g]),
            .BUSY     (busy[g]),
            .DONE     (done[g]),
            .SUM      (s),
            .CARRY_OUT(co[g]),
            .OVERFLOW (ov[g])
        );
        assign sumw[g] = 16'(s);
    end

    // Reference: unsigned and signed integer arithmetic on the operand values.
    function automatic void ref_op(input int w, input logic [15:0] av,
                                   input logic [15:0] bv, input logic ci,
                                   input logic sb, output logic [15:0] s,
                                   output logic c, output logic o);
        longint full = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint ua = longint'(av) & (full - 1);
        longint ub = longint'(bv) & (full - 1);
        longint sa = (ua >= half) ? ua - full : ua;
        longint sbv = (ub >= half) ? ub - full : ub;
        longint c0 = ci ? 1 : 0;
        longint ures;
        longint sres;
        if (sb) begin
            ures = ua - ub;
            sres = sa - sbv;
            c = (ua >= ub);
        end else begin
            ures = ua + ub + c0;
            sres = sa + sbv + c0;
            c = (ures >= full);
        end
        s = 16'(ures & (full - 1));
        o = (sres >= half) || (sres < -half);
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_op(input int k, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input logic sb, input bit keep,
                          output int lat, output int nbusy,
                          output logic [15:0] rs, output logic rc,
                          output logic ro, output bit to);
        a[k] = av;
        b[k] = bv;
        cin[k] = ci;
        sub[k] = sb;
        start[k] = 1'b1;
        @(posedge clk);
        lat = 0;
        nbusy = 0;
        to = 1'b1;
        rs = '0;
        rc = 1'b0;
        ro = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!keep) start[k] = 1'b0;
            if (done[k]) begin
                lat = i - 1;
                rs = sumw[k];
                rc = co[k];
                ro = ov[k];
                to = 1'b0;
                break;
            end
            if (busy[k]) nbusy++;
            a[k] = 16'($urandom);
            b[k] = 16'($urandom);
            cin[k] = 1'($urandom);
            sub[k] = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = '0;
        cin = '0;
        sub = '0;
        for (int k = 0; k < NC; k++) begin
            a[k] = '0;
            b[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            vecs++;
            if ({busy[k], done[k], co[k], ov[k], sumw[k]} !== 20'h0) begin
                errs++;
                $display("FAIL reset[%0d]: busy=%b done=%b co=%b ov=%b sum=%h want all 0",
                         k, busy[k], done[k], co[k], ov[k], sumw[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        int nb;
        logic [15:0] rs;
        logic rc;
        logic ro;
        bit to;
        @(negedge clk);
        run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0, lat, nb, rs, rc, ro, to);
        vecs++;
        if (to || lat !== 4 || nb !== 4) begin
            errs++;
            $display("FAIL dir_timing: to=%0d lat=%0d busy=%0d want lat=4 busy=4",
                     to, lat, nb);
        end
        vecs++;
        if ({rs[7:0], rc, ro} !== {8'h00, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL dir_ff+01: sum=%h co=%b ov=%b want 00 1 0", rs, rc, ro);
        end
        run_op(0, 16'h7F, 16'h01, 1'b1, 1'b0, 1'b0, lat, nb, rs, rc, ro, to);
        vecs++;
        if (to || {rs[7:0], rc, ro} !== {8'h81, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL dir_7f+01+1: to=%0d sum=%h co=%b ov=%b want 81 0 1",
                     to, rs, rc, ro);
        end
        run_op(0, 16'h05, 16'h07, 1'b1, 1'b1, 1'b0, lat, nb, rs, rc, ro, to);
        vecs++;
        if (to || {rs[7:0], rc, ro} !== {8'hFE, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL dir_05-07: to=%0d sum=%h co=%b ov=%b want fe 0 0",
                     to, rs, rc, ro);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int nb;
        logic [15:0] rs;
        logic [15:0] es;
        logic rc;
        logic ro;
        logic ec;
        logic eo;
        logic [15:0] av;
        logic [15:0] bv;
        logic ci;
        logic sb;
        bit to;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            run_op(0, av, bv, ci, sb, i < 7, lat, nb, rs, rc, ro, to);
            ref_op(8, av, bv, ci, sb, es, ec, eo);
            vecs++;
            if (to || lat !== 4 || {rs, rc, ro} !== {es, ec, eo}) begin
                errs++;
                $display("FAIL b2b[%0d]: to=%0d lat=%0d sum=%h co=%b ov=%b want lat=4 %h %b %b",
                         i, to, lat, rs, rc, ro, es, ec, eo);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        int nb;
        int ndone;
        logic [15:0] rs;
        logic rc;
        logic ro;
        bit to;
        @(negedge clk);
        a[0] = 16'h7F;
        b[0] = 16'h01;
        cin[0] = 1'b1;
        sub[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vecs++;
        if ({busy[0], done[0], co[0], ov[0], sumw[0]} !== 20'h0) begin
            errs++;
            $display("FAIL midrun_reset: busy=%b done=%b co=%b ov=%b sum=%h want all 0",
                     busy[0], done[0], co[0], ov[0], sumw[0]);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[0] || busy[0]) ndone++;
        end
        vecs++;
        if (ndone !== 0) begin
            errs++;
            $display("FAIL midrun_abort: %0d busy/done cycles seen want 0", ndone);
        end
        run_op(0, 16'h10, 16'h20, 1'b0, 1'b0, 1'b0, lat, nb, rs, rc, ro, to);
        vecs++;
        if (to || {rs[7:0], rc, ro} !== {8'h30, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL midrun_after: to=%0d sum=%h co=%b ov=%b want 30 0 0",
                     to, rs, rc, ro);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int nb;
        logic [15:0] rs;
        logic [15:0] es;
        logic rc;
        logic ro;
        logic ec;
        logic eo;
        logic [15:0] av;
        logic [15:0] bv;
        logic ci;
        logic sb;
        bit to;
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            for (int i = 0; i < 30; i++) begin
                av = 16'($urandom);
                bv = 16'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                if (i < 4) begin
                    av = (i[0]) ? 16'hFFFF : 16'h0000;
                    bv = (i[1]) ? 16'hFFFF : 16'h0000;
                end
                run_op(k, av, bv, ci, sb, (i < 29) && ($urandom_range(1) == 1),
                       lat, nb, rs, rc, ro, to);
                ref_op(WS[k], av, bv, ci, sb, es, ec, eo);
                vecs++;
                if (to || lat !== WS[k] / DS[k] || nb !== WS[k] / DS[k]) begin
                    errs++;
                    $display("FAIL sweep_timing w%0d d%0d: to=%0d lat=%0d busy=%0d want %0d",
                             WS[k], DS[k], to, lat, nb, WS[k] / DS[k]);
                end
                vecs++;
                if ({rs, rc, ro} !== {es, ec, eo}) begin
                    errs++;
                    $display("FAIL sweep w%0d d%0d a=%h b=%h ci=%b sub=%b: sum=%h co=%b ov=%b want %h %b %b",
                             WS[k], DS[k], av, bv, ci, sb, rs, rc, ro, es, ec, eo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midrun();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
